score_table: RTL and testbench

SCORE_TABLE -- requirements
Module: score_table

---
 rtl/score_table_pkg.sv | 20 ++
 rtl/score_table_if.sv | 31 +++
 rtl/button_edge.sv | 25 ++
 rtl/score_table.sv | 170 +++++++++++++++++
 tb/tb_score_table.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/score_table_pkg.sv
// Shared constants for the high-score table: game phases, button bit positions
// and the insertion FSM state encoding.
package score_table_pkg;

   localparam logic [1:0] GS_IDLE  = 2'd0;
   localparam logic [1:0] GS_PLAY  = 2'd1;
   localparam logic [1:0] GS_OVER  = 2'd2;
   localparam logic [1:0] GS_BOARD = 2'd3;

   localparam int BTN_NEXT = 0;
   localparam int BTN_PREV = 1;
   localparam int BTN_EXIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_WRITE = 2'd2
   } fsm_state_t;

endpackage

// File: rtl/score_table_if.sv
// Bundle of game-side inputs and scoreboard outputs for score_table.
interface score_table_if #(
   parameter int DEPTH   = 8,
   parameter int ID_W    = 16,
   parameter int SCORE_W = 16
) ();

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [2:0]             buttons;
   logic [ID_W-1:0]        user_id;
   logic [SCORE_W-1:0]     score;
   logic [1:0]             game_state;
   logic                   busy;
   logic [CNT_W-1:0]       entry_count;
   logic [IDX_W-1:0]       display_index;
   logic [ID_W+SCORE_W-1:0] display_data;
   logic                   scoreboard_eof;

   modport master (
      output buttons, user_id, score, game_state,
      input  busy, entry_count, display_index, display_data, scoreboard_eof
   );

   modport slave (
      input  buttons, user_id, score, game_state,
      output busy, entry_count, display_index, display_data, scoreboard_eof
   );

endinterface

// File: rtl/button_edge.sv
// Registered rising-edge detector: each low-to-high transition of a button
// produces a single-cycle pulse one cycle later.
module button_edge (
   input  logic       clk,
   input  logic       srst,
   input  logic [2:0] buttons,
   output logic [2:0] rise
);

   logic [2:0] prev_reg;
   logic [2:0] rise_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         prev_reg <= '0;
         rise_reg <= '0;
      end else begin
         prev_reg <= buttons;
         rise_reg <= buttons & ~prev_reg;
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/score_table.sv
// Ranked high-score table with one-rank-per-cycle insertion sort and a
// button-driven board view.
module score_table
   import score_table_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int ID_W    = 16,
   parameter int SCORE_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   score_table_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_RANK = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [1:0]         gs_reg;
   fsm_state_t         state_reg;
   logic [IDX_W-1:0]   ptr_reg;
   logic [ID_W-1:0]    new_id_reg;
   logic [SCORE_W-1:0] new_score_reg;
   logic               busy_reg;
   logic [CNT_W-1:0]   count_reg;

   logic               valid_reg  [DEPTH];
   logic [ID_W-1:0]    ids_reg    [DEPTH];
   logic [SCORE_W-1:0] scores_reg [DEPTH];

   logic [IDX_W-1:0]        idx_reg;
   logic [ID_W+SCORE_W-1:0] data_reg;
   logic                    eof_reg;

   logic [DEPTH-1:0] move_down;
   logic             trigger;
   logic             discard;
   logic [2:0]       btn_rise;

   // move_down[i]: rank i-1 must slide into rank i to make room for the new
   // entry. Empty ranks slide too, which keeps valid entries packed at the top.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_move
         if (gi == 0) begin : g_top
            assign move_down[gi] = 1'b0;
         end else begin : g_rank
            assign move_down[gi] = !valid_reg[gi-1] || (scores_reg[gi-1] < new_score_reg);
         end
      end
   endgenerate

   assign trigger = (bus.game_state == GS_OVER) && (gs_reg != GS_OVER) && (state_reg == ST_IDLE);
   assign discard = valid_reg[DEPTH-1] && (new_score_reg <= scores_reg[DEPTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         gs_reg <= GS_IDLE;
      end else begin
         gs_reg <= bus.game_state;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         new_id_reg    <= '0;
         new_score_reg <= '0;
         busy_reg      <= 1'b0;
         count_reg     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            valid_reg[i]  <= 1'b0;
            ids_reg[i]    <= '0;
            scores_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (trigger) begin
                  new_id_reg    <= bus.user_id;
                  new_score_reg <= bus.score;
                  ptr_reg       <= LAST_RANK;
                  busy_reg      <= 1'b1;
                  state_reg     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // A full table whose last score already beats the newcomer stays untouched.
               if (ptr_reg == LAST_RANK && discard) begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (move_down[ptr_reg]) begin
                  valid_reg[ptr_reg]  <= valid_reg[ptr_reg - 1'b1];
                  ids_reg[ptr_reg]    <= ids_reg[ptr_reg - 1'b1];
                  scores_reg[ptr_reg] <= scores_reg[ptr_reg - 1'b1];
                  ptr_reg             <= ptr_reg - 1'b1;
               end else begin
                  state_reg <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               valid_reg[ptr_reg]  <= 1'b1;
               ids_reg[ptr_reg]    <= new_id_reg;
               scores_reg[ptr_reg] <= new_score_reg;
               if (count_reg != FULL_COUNT) begin
                  count_reg <= count_reg + 1'b1;
               end
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   button_edge u_button_edge (
      .clk     (clk),
      .srst    (rst),
      .buttons (bus.buttons),
      .rise    (btn_rise)
   );

   logic             board_active;
   logic             enter_board;
   logic [IDX_W-1:0] last_idx;
   logic             go_next;
   logic             go_prev;

   assign board_active = (bus.game_state == GS_BOARD) && !busy_reg;
   assign enter_board  = (bus.game_state == GS_BOARD) && (gs_reg != GS_BOARD);
   assign last_idx     = IDX_W'(count_reg - CNT_W'(1));
   assign go_next      = btn_rise[BTN_NEXT] && !btn_rise[BTN_PREV];
   assign go_prev      = btn_rise[BTN_PREV] && !btn_rise[BTN_NEXT];

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg  <= '0;
         data_reg <= '0;
         eof_reg  <= 1'b0;
      end else begin
         eof_reg <= board_active && btn_rise[BTN_EXIT];
         if (enter_board) begin
            idx_reg <= '0;
         end else if (board_active) begin
            if (btn_rise[BTN_EXIT]) begin
               idx_reg <= '0;
            end else if (go_next) begin
               idx_reg <= (count_reg == '0 || idx_reg == last_idx) ? '0 : idx_reg + 1'b1;
            end else if (go_prev) begin
               if (idx_reg == '0) begin
                  idx_reg <= (count_reg == '0) ? '0 : last_idx;
               end else begin
                  idx_reg <= idx_reg - 1'b1;
               end
            end
         end
         data_reg <= valid_reg[idx_reg] ? {ids_reg[idx_reg], scores_reg[idx_reg]} : '0;
      end
   end

   assign bus.busy           = busy_reg;
   assign bus.entry_count    = count_reg;
   assign bus.display_index  = idx_reg;
   assign bus.display_data   = data_reg;
   assign bus.scoreboard_eof = eof_reg;

endmodule

// File: tb/tb_score_table.sv
// Directed bench for score_table at DEPTH=4: vector table of inserts plus
// hand-written board, exit, reset-abort and re-trigger sequences.
module tb_score_table;

   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   score_table_if #(.DEPTH(DEPTH), .ID_W(16), .SCORE_W(16)) bus ();

   score_table #(.DEPTH(DEPTH), .ID_W(16), .SCORE_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int               id;
      int               sc;
      int               cnt;
      bit               discard;
      logic [3:0][31:0] exp;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [31:0] mk(input int id, input int sc);
      return {id[15:0], sc[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [2:0] b);
      bus.buttons = b;
      tick();
      bus.buttons = 3'b000;
      tick();
      tick();
   endtask

   task automatic do_insert(input int id, input int sc, output int cyc);
      bus.game_state = 2'd1;
      tick();
      bus.user_id    = 16'(id);
      bus.score      = 16'(sc);
      bus.game_state = 2'd2;
      tick();
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < DEPTH + 4) begin
         cyc++;
         tick();
      end
      $display("insert id=%0d score=%0d busy_cycles=%0d entry_count=%0d", id, sc, cyc, bus.entry_count);
      check("busy_seen", 64'(cyc >= 1), 64'd1);
      check("busy_bound", 64'(cyc <= DEPTH + 2), 64'd1);
   endtask

   task automatic read_table(input int cnt, input logic [3:0][31:0] exp, input string tag);
      bus.game_state = 2'd3;
      tick();
      tick();
      for (int r = 0; r < cnt; r++) begin
         if (r > 0) press(3'b001);
         check($sformatf("%s idx%0d", tag, r), 64'(bus.display_index), 64'(r));
         check($sformatf("%s rank%0d", tag, r), 64'(bus.display_data), 64'(exp[r]));
      end
   endtask

   initial begin
      int cyc;
      logic [3:0][31:0] e;
      n_cmp = 0;
      n_bad = 0;

      // exp is listed rank3 .. rank0
      vecs[0] = '{id: 1, sc: 50, cnt: 1, discard: 1'b0, exp: {32'h0, 32'h0, 32'h0, mk(1, 50)}};
      vecs[1] = '{id: 2, sc: 80, cnt: 2, discard: 1'b0, exp: {32'h0, 32'h0, mk(1, 50), mk(2, 80)}};
      vecs[2] = '{id: 3, sc: 20, cnt: 3, discard: 1'b0, exp: {32'h0, mk(3, 20), mk(1, 50), mk(2, 80)}};
      vecs[3] = '{id: 4, sc: 80, cnt: 4, discard: 1'b0, exp: {mk(3, 20), mk(1, 50), mk(4, 80), mk(2, 80)}};
      vecs[4] = '{id: 5, sc: 20, cnt: 4, discard: 1'b1, exp: {mk(3, 20), mk(1, 50), mk(4, 80), mk(2, 80)}};
      vecs[5] = '{id: 6, sc: 90, cnt: 4, discard: 1'b0, exp: {mk(1, 50), mk(4, 80), mk(2, 80), mk(6, 90)}};

      rst            = 1'b1;
      bus.buttons    = 3'b000;
      bus.user_id    = '0;
      bus.score      = '0;
      bus.game_state = 2'd0;
      repeat (3) tick();
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset entry_count", 64'(bus.entry_count), 64'd0);
      check("reset display_index", 64'(bus.display_index), 64'd0);
      check("reset display_data", 64'(bus.display_data), 64'd0);
      check("reset eof", 64'(bus.scoreboard_eof), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         do_insert(vecs[i].id, vecs[i].sc, cyc);
         if (vecs[i].discard) check($sformatf("vec%0d discard busy", i), 64'(cyc), 64'd1);
         check($sformatf("vec%0d entry_count", i), 64'(bus.entry_count), 64'(vecs[i].cnt));
         read_table(vecs[i].cnt, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Reset two cycles into SHIFT must leave an empty table.
      bus.game_state = 2'd1;
      tick();
      bus.user_id    = 16'd11;
      bus.score      = 16'd100;
      bus.game_state = 2'd2;
      tick();
      check("abort busy after trigger", 64'(bus.busy), 64'd1);
      tick();
      rst            = 1'b1;
      bus.game_state = 2'd1;
      tick();
      rst = 1'b0;
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort entry_count", 64'(bus.entry_count), 64'd0);
      tick();
      check("abort entry_count later", 64'(bus.entry_count), 64'd0);
      bus.game_state = 2'd3;
      tick();
      tick();
      check("abort rank0 empty", 64'(bus.display_data), 64'd0);
      press(3'b001);
      check("empty next idx", 64'(bus.display_index), 64'd0);
      $display("reset-abort sequence done");

      do_insert(7, 30, cyc);
      do_insert(8, 20, cyc);
      do_insert(9, 10, cyc);
      check("three entry_count", 64'(bus.entry_count), 64'd3);

      bus.game_state = 2'd3;
      tick();
      tick();
      check("board idx0", 64'(bus.display_index), 64'd0);
      press(3'b010);
      check("prev wrap idx", 64'(bus.display_index), 64'd2);
      check("prev wrap data", 64'(bus.display_data), 64'(mk(9, 10)));
      press(3'b001);
      check("next1 idx", 64'(bus.display_index), 64'd0);
      check("next1 data", 64'(bus.display_data), 64'(mk(7, 30)));
      press(3'b001);
      check("next2 idx", 64'(bus.display_index), 64'd1);
      check("next2 data", 64'(bus.display_data), 64'(mk(8, 20)));
      press(3'b001);
      check("next3 idx", 64'(bus.display_index), 64'd2);
      press(3'b011);
      check("next+prev idx", 64'(bus.display_index), 64'd2);
      $display("board navigation sequence done");

      bus.buttons = 3'b101;
      tick();
      bus.buttons = 3'b000;
      check("eof before", 64'(bus.scoreboard_eof), 64'd0);
      tick();
      check("eof pulse", 64'(bus.scoreboard_eof), 64'd1);
      check("exit idx", 64'(bus.display_index), 64'd0);
      tick();
      check("eof cleared", 64'(bus.scoreboard_eof), 64'd0);
      check("exit idx held", 64'(bus.display_index), 64'd0);
      $display("exit sequence done");

      // Second OVER edge lands while busy and must be ignored.
      bus.game_state = 2'd1;
      tick();
      bus.user_id    = 16'd10;
      bus.score      = 16'd25;
      bus.game_state = 2'd2;
      tick();
      cyc = 0;
      for (int k = 0; k < 12; k++) begin
         if (bus.busy === 1'b1) cyc++;
         if (k == 0) bus.game_state = 2'd1;
         if (k == 1) bus.game_state = 2'd2;
         tick();
      end
      $display("retrigger insert id=10 score=25 busy_cycles=%0d", cyc);
      check("retrigger busy cycles", 64'(cyc), 64'd4);
      check("retrigger entry_count", 64'(bus.entry_count), 64'd4);
      e = {mk(9, 10), mk(8, 20), mk(10, 25), mk(7, 30)};
      read_table(4, e, "retrig");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
